// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer.
// Opaque DW-bit payload, valid/ready flow control and synchronous flush.
`timescale 1ns/1ps

module pipe_stage_skid #(
    parameter int unsigned DW             = 32,
    parameter bit          SKID_EN        = 1'b1,
    parameter bit          CLEAR_ON_FLUSH = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    occupancy_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          valid_q;
    logic          ready_q;
    logic [1:0]    occ_q;
    logic          in_fire;

    assign in_fire = in_valid_i & in_ready_o;

    // With the skid buffer, upstream ready is a flop so out_ready_i never
    // reaches in_ready_o combinationally; without it, ready looks through.
    assign in_ready_o  = SKID_EN ? ready_q : (~valid_q | out_ready_i);
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = occ_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            occ_q   <= 2'd0;
        end else if (flush_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            occ_q   <= 2'd0;
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data_i;
                        state_q <= FULL;
                        valid_q <= 1'b1;
                        occ_q   <= 2'd1;
                    end
                end
                FULL: begin
                    if (in_fire && out_ready_i) begin
                        main_q <= in_data_i;
                    end else if (out_ready_i) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                        occ_q   <= 2'd0;
                    end else if (in_fire && SKID_EN) begin
                        skid_q  <= in_data_i;
                        state_q <= SKID;
                        ready_q <= 1'b0;
                        occ_q   <= 2'd2;
                    end
                end
                SKID: begin
                    if (out_ready_i) begin
                        main_q  <= skid_q;
                        state_q <= FULL;
                        ready_q <= 1'b1;
                        occ_q   <= 2'd1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    occ_q   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline stage register for the 3-stage core. It generalises the fixed-field stage registers with an opaque payload of width DW, valid/ready flow control and a synchronous flush. An optional 2-entry skid buffer lets the stage accept data while the downstream stage stalls, and registers the upstream ready so it has no combinational path from out_ready_i. It sits between decode/execute and memory/writeback; flush_i is driven by branch/jump redirect.

## Interface
- DW, 32: payload width in bits (≥1); callers concatenate control and data fields.
- SKID_EN, 1: 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.
- CLEAR_ON_FLUSH, 0: 1 = data registers are zeroed on flush; 0 = data registers hold their value and only valid bits clear.

- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- flush_i  input  1  synchronous kill of all held entries.
- in_valid_i  input  1  upstream payload valid.
- in_ready_o  output  1  stage can accept a payload this cycle.
- in_data_i  input  DW  upstream payload.
- out_valid_o  output  1  out_data_o holds a valid payload.
- out_ready_i  input  1  downstream accepts this cycle.
- out_data_o  output  DW  payload; driven directly from the main register.
- occupancy_o  output  2  number of valid entries held (0, 1, or 2).

## Operation
- Transfer in: in_valid_i & in_ready_o at the clock edge. Transfer out: out_valid_o & out_ready_i at the clock edge.
- Storage: main register (drives out_data_o) and skid register. The skid register exists only if SKID_EN=1.
- States: EMPTY (occupancy 0), FULL (1), SKID (2, only if SKID_EN=1).
- EMPTY: out_valid_o=0, in_ready_o=1. If in_valid_i, main <= in_data_i and go to FULL.
- FULL, SKID_EN=1: out_valid_o=1, in_ready_o=1.
  - in & out: main <= in_data_i, stay FULL.
  - out only: go to EMPTY.
  - in only: skid <= in_data_i, go to SKID.
  - Neither: hold.
- SKID: out_valid_o=1, in_ready_o=0. If out_ready_i, main <= skid and go to FULL; otherwise hold.
- SKID_EN=0: in_ready_o = ~out_valid_o | out_ready_i (combinational). FULL with in & out reloads main. FULL with out only goes to EMPTY. FULL with in only cannot occur.
- Flush priority: flush_i > transfers.
  - Go to EMPTY; any input presented that cycle is dropped.
  - An output transfer coinciding with the flush still counts downstream, and the stage still ends EMPTY.
  - If CLEAR_ON_FLUSH=1, main and skid are zeroed.
- Ordering: payloads leave in arrival order; no payload is duplicated or lost except by flush.
- occupancy_o is a direct function of state.

## Timing
- Reset: state EMPTY, out_valid_o=0, out_data_o=0, skid=0, occupancy_o=0, in_ready_o=1. All effective immediately on rst_i assertion, independent of clk_i.
- Reset deasserted mid-stream: first acceptance occurs at the first rising edge with rst_i low.
- Latency: an accepted payload is visible on out_data_o with out_valid_o=1 the cycle after acceptance. Minimum latency is 1 cycle.
- Throughput: 1 payload/cycle when out_ready_i is held high.
- SKID_EN=1: in_ready_o is a pure register output (no combinational path from out_ready_i).
  - One stall cycle absorbs one extra payload; in_ready_o drops the cycle after.
  - After SKID → FULL, in_ready_o rises the same cycle the state changes.
- SKID_EN=0: a stall cycle with FULL holds in_ready_o low combinationally the same cycle.
- out_data_o never changes while out_valid_o=1 and out_ready_i=0 (stable-while-stalled rule).
- out_valid_o never drops without a transfer or flush.

## Test plan
- Streaming, SKID_EN=1, DW=32: 8 back-to-back inputs 0x00000001..0x00000008 with out_ready_i=1 → the same sequence on out_data_o, one per cycle, starting 1 cycle after the first accept; occupancy_o=1 throughout.
- Skid stall: FULL with 0xA, hold out_ready_i=0 while presenting 0xB then 0xC → 0xB is accepted and 0xC is not (in_ready_o=0, occupancy_o=2, out_data_o stays 0xA). Raise out_ready_i → output order 0xA, 0xB, 0xC with no loss or duplication.
- SKID_EN=0 stall: FULL, out_ready_i=0 → in_ready_o=0 in the same cycle. Set out_ready_i=1 with 0x55 presented → 0x55 is accepted and out_data_o=0x55 next cycle.
- Flush in SKID state with a simultaneous valid input 0x99, CLEAR_ON_FLUSH=1 → next cycle: EMPTY, out_valid_o=0, out_data_o=0, occupancy_o=0, and 0x99 never appears on the output.
- Asynchronous reset asserted mid-cycle while in SKID → out_valid_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1 before the next clock edge. After release, a new input 0x1234 appears on out_data_o 1 cycle after acceptance.
- Random valid/ready: 10k cycles with a scoreboard → outputs match inputs in order, out_data_o stays stable during stalls, and occupancy_o never exceeds 2 (never exceeds 1 when SKID_EN=0).
